// File: rtl/admm_pkg.sv
// Shared definitions for the ADMM iteration scheduler.
//   admm_state_t      : scheduler FSM states
//   DEF_HORIZON       : default number of horizon knots
//   DEF_STAGE_TIMEOUT : default per-stage watchdog limit in cycles
package admm_pkg;

  localparam int DEF_HORIZON       = 10;
  localparam int DEF_STAGE_TIMEOUT = 1024;

  typedef enum logic [3:0] {
    IDLE,
    P_GO,
    P_WAIT,
    S_GO,
    S_WAIT,
    D_GO,
    D_WAIT,
    R_GO,
    R_WAIT,
    FIN,
    ERR
  } admm_state_t;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: a clear/enable up-counter with an expire flag.
//   clk, reset : clock, async active-low reset
//   clear      : zero the count (held while a stage is being launched)
//   enable     : count this cycle (stage is waiting for its done)
//   expire     : the stage has now waited LIMIT-1 cycles without finishing
module stage_watchdog
  import admm_pkg::*;
#(
  parameter int LIMIT = DEF_STAGE_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires in the wait cycle whose increment would bring the count to
  // LIMIT-1, so the abort state is entered exactly LIMIT cycles after
  // the stage start pulse.
  assign expire = enable && (cnt == CW'(LIMIT - 2));

endmodule

// File: rtl/admm_iter_ctrl.sv
// ADMM iteration scheduler. Per iteration it runs the primal solve once,
// then slack projection and dual update for every knot, then the residual
// check; it repeats until convergence or the iteration budget runs out.
//   clk, reset                 : clock, async active-low reset
//   start, horizon_len,
//   max_iter                   : solve request and its latched parameters
//   <stage>_start/<stage>_done : handshakes to primal/slack/dual/resid engines
//   resid_converged            : qualifies resid_done
//   knot_idx, iter_cnt         : current knot, completed iterations
//   busy, done, converged,
//   error                      : solve status
//
// state  | meaning
// IDLE   | waiting for start
// P_GO   | pulse primal_start
// P_WAIT | wait for primal_done
// S_GO   | pulse slack_start for knot_idx
// S_WAIT | wait for slack_done
// D_GO   | pulse dual_start for knot_idx
// D_WAIT | wait for dual_done, then next knot or residual
// R_GO   | pulse resid_start
// R_WAIT | wait for resid_done, then finish or iterate again
// FIN    | solve ended normally, pulse done
// ERR    | a stage timed out, pulse done with error
module admm_iter_ctrl
  import admm_pkg::*;
#(
  parameter int HORIZON       = DEF_HORIZON,
  parameter int MAX_ITER_W    = 8,
  parameter int STAGE_TIMEOUT = DEF_STAGE_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(HORIZON+1)-1:0] horizon_len,
  input  logic [MAX_ITER_W-1:0]        max_iter,
  output logic                         primal_start,
  input  logic                         primal_done,
  output logic                         slack_start,
  input  logic                         slack_done,
  output logic                         dual_start,
  input  logic                         dual_done,
  output logic                         resid_start,
  input  logic                         resid_done,
  input  logic                         resid_converged,
  output logic [$clog2(HORIZON)-1:0]   knot_idx,
  output logic [MAX_ITER_W-1:0]        iter_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         converged,
  output logic                         error
);

  localparam int HLW = $clog2(HORIZON + 1);
  localparam int KW  = $clog2(HORIZON);

  admm_state_t state, state_nxt;

  logic [HLW-1:0]        n_in;
  logic [HLW-1:0]        n_lat;
  logic [MAX_ITER_W-1:0] max_lat;
  logic                  last_knot;
  logic                  last_iter;
  logic                  wd_clear;
  logic                  wd_en;
  logic                  wd_expire;

  // Out-of-range knot counts are folded into 1..HORIZON at latch time.
  always_comb begin
    n_in = horizon_len;
    if (horizon_len == '0) begin
      n_in = HLW'(1);
    end else if (horizon_len > HLW'(HORIZON)) begin
      n_in = HLW'(HORIZON);
    end
  end

  assign last_knot = ((HLW'(knot_idx) + HLW'(1)) == n_lat);
  // One extra bit so the +1 cannot wrap before the compare.
  assign last_iter = (({1'b0, iter_cnt} + (MAX_ITER_W + 1)'(1)) == {1'b0, max_lat});

  stage_watchdog #(
    .LIMIT (STAGE_TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Done is always checked before the watchdog, so a stage finishing in
  // the expiry cycle still counts as success.
  always_comb begin
    state_nxt    = state;
    primal_start = 1'b0;
    slack_start  = 1'b0;
    dual_start   = 1'b0;
    resid_start  = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    wd_clear     = 1'b0;
    wd_en        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = P_GO;
      end
      P_GO: begin
        primal_start = 1'b1;
        wd_clear     = 1'b1;
        state_nxt    = P_WAIT;
      end
      P_WAIT: begin
        wd_en = 1'b1;
        if (primal_done)    state_nxt = S_GO;
        else if (wd_expire) state_nxt = ERR;
      end
      S_GO: begin
        slack_start = 1'b1;
        wd_clear    = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        wd_en = 1'b1;
        if (slack_done)     state_nxt = D_GO;
        else if (wd_expire) state_nxt = ERR;
      end
      D_GO: begin
        dual_start = 1'b1;
        wd_clear   = 1'b1;
        state_nxt  = D_WAIT;
      end
      D_WAIT: begin
        wd_en = 1'b1;
        if (dual_done)      state_nxt = last_knot ? R_GO : S_GO;
        else if (wd_expire) state_nxt = ERR;
      end
      R_GO: begin
        resid_start = 1'b1;
        wd_clear    = 1'b1;
        state_nxt   = R_WAIT;
      end
      R_WAIT: begin
        wd_en = 1'b1;
        if (resid_done)     state_nxt = (resid_converged || last_iter) ? FIN : P_GO;
        else if (wd_expire) state_nxt = ERR;
      end
      FIN: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_lat     <= '0;
      max_lat   <= '0;
      knot_idx  <= '0;
      iter_cnt  <= '0;
      converged <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_lat     <= n_in;
            max_lat   <= (max_iter == '0) ? MAX_ITER_W'(1) : max_iter;
            knot_idx  <= '0;
            iter_cnt  <= '0;
            converged <= 1'b0;
            error     <= 1'b0;
          end
        end
        D_WAIT: begin
          // Knot index returns to 0 as soon as the knot loop is left.
          if (dual_done) knot_idx <= last_knot ? '0 : knot_idx + KW'(1);
        end
        R_WAIT: begin
          if (resid_done) begin
            iter_cnt <= iter_cnt + MAX_ITER_W'(1);
            if (resid_converged) converged <= 1'b1;
          end
        end
        default: ;
      endcase
      if (state_nxt == ERR) begin
        error    <= 1'b1;
        knot_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_admm_iter_ctrl.sv
`timescale 1ns/1ps
module tb_admm_iter_ctrl;
  import admm_pkg::*;

  localparam int HORIZON       = 10;
  localparam int MAX_ITER_W    = 8;
  localparam int STAGE_TIMEOUT = 1024;
  localparam int HLW           = $clog2(HORIZON + 1);
  localparam int KW            = $clog2(HORIZON);

  typedef struct {int stage; int knot;} ev_t;
  typedef struct {int iters; int conv; int err; int primals;} res_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [HLW-1:0]        horizon_len = '0;
  logic [MAX_ITER_W-1:0] max_iter = '0;
  logic primal_start, slack_start, dual_start, resid_start;
  logic primal_done, slack_done, dual_done, resid_done, resid_converged;
  logic [KW-1:0]         knot_idx;
  logic [MAX_ITER_W-1:0] iter_cnt;
  logic busy, done, converged, error;

  logic [3:0] st;
  logic [3:0] dn_m = '0;
  logic       spur_slack = 1'b0;
  logic       conv_pend = 1'b0;
  int lat[4];
  int cnt[4];
  int withhold_knot = -1;
  int conv_iter = 0;
  int resid_seen = 0;

  ev_t exp_ev[$];
  res_t exp_res[$];
  int checks = 0;
  int errors = 0;
  int primal_seen = 0;
  ev_t me;
  res_t mr;

  always #5 clk = ~clk;

  admm_iter_ctrl #(
    .HORIZON(HORIZON), .MAX_ITER_W(MAX_ITER_W), .STAGE_TIMEOUT(STAGE_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .horizon_len(horizon_len), .max_iter(max_iter),
    .primal_start(primal_start), .primal_done(primal_done),
    .slack_start(slack_start), .slack_done(slack_done),
    .dual_start(dual_start), .dual_done(dual_done),
    .resid_start(resid_start), .resid_done(resid_done), .resid_converged(resid_converged),
    .knot_idx(knot_idx), .iter_cnt(iter_cnt), .busy(busy), .done(done),
    .converged(converged), .error(error)
  );

  assign st              = {resid_start, dual_start, slack_start, primal_start};
  assign primal_done     = dn_m[0];
  assign slack_done      = dn_m[1] | spur_slack;
  assign dual_done       = dn_m[2];
  assign resid_done      = dn_m[3];
  assign resid_converged = dn_m[3] & conv_pend;

  // Engine models: done rises lat[i] wait cycles after the start pulse.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      dn_m = '0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      resid_seen = 0;
      conv_pend = 1'b0;
    end else begin
      if (done) resid_seen = 0;
      for (int i = 0; i < 4; i++) begin
        dn_m[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) dn_m[i] = 1'b1;
        end
        if (st[i] && !(i == 2 && int'(knot_idx) == withhold_knot)) cnt[i] = lat[i];
        if (st[i] && i == 3) begin
          resid_seen++;
          conv_pend = (resid_seen == conv_iter);
        end
      end
    end
  end

  // Monitor: every start pulse and every done retires one scoreboard entry.
  always @(negedge clk) begin
    if (!reset) begin
      primal_seen = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (st[i]) begin
          if (i == 0) primal_seen++;
          checks++;
          if (exp_ev.size() == 0) begin
            errors++;
            $display("FAIL start_seq: got stage %0d knot %0d, required no start", i, knot_idx);
          end else begin
            me = exp_ev.pop_front();
            if (me.stage != i || me.knot != int'(knot_idx)) begin
              errors++;
              $display("FAIL start_seq: got stage %0d knot %0d, required stage %0d knot %0d",
                       i, knot_idx, me.stage, me.knot);
            end
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_res.size() == 0) begin
          errors++;
          $display("FAIL done_result: got unexpected done, required none");
        end else begin
          mr = exp_res.pop_front();
          if (int'(iter_cnt) != mr.iters || int'(converged) != mr.conv || int'(error) != mr.err ||
              primal_seen != mr.primals || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_result: got iter=%0d conv=%0d err=%0d primals=%0d busy=%0d, required iter=%0d conv=%0d err=%0d primals=%0d busy=0",
                     iter_cnt, converged, error, primal_seen, busy, mr.iters, mr.conv, mr.err, mr.primals);
          end
        end
        primal_seen = 0;
      end
    end
  end

  task automatic push_ev(input int s, input int k);
    ev_t e;
    e.stage = s;
    e.knot  = k;
    exp_ev.push_back(e);
  endtask

  task automatic push_run(input int n, input int iters, input int conv);
    res_t r;
    for (int it = 0; it < iters; it++) begin
      push_ev(0, 0);
      for (int k = 0; k < n; k++) begin
        push_ev(1, k);
        push_ev(2, k);
      end
      push_ev(3, 0);
    end
    r.iters = iters; r.conv = conv; r.err = 0; r.primals = iters;
    exp_res.push_back(r);
  endtask

  task automatic set_lat(input int l);
    for (int i = 0; i < 4; i++) lat[i] = l;
  endtask

  task automatic run_start(input int n, input int mi);
    @(negedge clk);
    horizon_len = HLW'(n);
    max_iter    = MAX_ITER_W'(mi);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done, required done within %0d cycles", tag, budget);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    logic [23:0] v;
    v = {primal_start, slack_start, dual_start, resid_start, busy, done, converged, error,
         4'(knot_idx), iter_cnt, 4'b0};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: got outputs 0x%06h, required 0", tag, v);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got simulation still running, required finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, pc, sp;
    bit got, found;
    set_lat(2);

    #2 reset = 1'b0;
    #1 check_all_zero("reset_values");
    @(negedge clk);
    #2 reset = 1'b1;

    // T1: N=3, max_iter=4, no convergence; start pulsed mid-solve.
    conv_iter = 0;
    push_run(3, 4, 0);
    run_start(3, 4);
    repeat (15) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(500, "t1");

    // T2: N=2, max_iter=10, converges on iteration 3; stray slack_done in P_WAIT.
    conv_iter = 3;
    push_run(2, 3, 1);
    run_start(2, 10);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (primal_start) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    spur_slack = 1'b1;
    @(negedge clk);
    spur_slack = 1'b0;
    wait_done(500, "t2");
    conv_iter = 0;

    // T3: N=1, immediate answers, max_iter=1: 9 cycles start to done.
    set_lat(1);
    push_run(1, 1, 0);
    @(negedge clk);
    horizon_len = HLW'(1);
    max_iter    = MAX_ITER_W'(1);
    start       = 1'b1;
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || cyc != 9) begin
      errors++;
      $display("FAIL latency_n1: got %0d cycles (done seen %0d), required 9", cyc, got);
    end
    @(negedge clk);

    // T4: horizon_len clamping (0 -> 1 knot, 15 -> HORIZON knots), max_iter 0 -> 1.
    push_run(1, 1, 0);
    run_start(0, 0);
    wait_done(100, "clamp_lo");
    push_run(HORIZON, 1, 0);
    run_start(15, 1);
    wait_done(200, "clamp_hi");

    // T5: dual_done withheld at knot 1 -> watchdog abort.
    push_ev(0, 0); push_ev(1, 0); push_ev(2, 0); push_ev(1, 1); push_ev(2, 1);
    mr.iters = 0; mr.conv = 0; mr.err = 1; mr.primals = 1;
    exp_res.push_back(mr);
    withhold_knot = 1;
    run_start(3, 2);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (dual_start && knot_idx == KW'(1)) begin
        found = 1'b1;
        break;
      end
    end
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < STAGE_TIMEOUT + 50; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || !got || cyc != STAGE_TIMEOUT || error !== 1'b1) begin
      errors++;
      $display("FAIL watchdog: got %0d cycles error=%0d (found %0d), required %0d cycles error=1",
               cyc, error, found, STAGE_TIMEOUT);
    end
    withhold_knot = -1;
    repeat (20) @(negedge clk);

    // T6: reset during D_WAIT of iteration 2, then a clean run.
    set_lat(2);
    push_run(2, 4, 0);
    run_start(2, 4);
    pc = 0;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (primal_start) pc++;
      if (pc == 2 && dual_start) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_setup: got no dual_start in iteration 2, required one");
    end
    @(negedge clk);
    #2 reset = 1'b0;
    exp_ev.delete();
    exp_res.delete();
    #1 check_all_zero("reset_mid_solve");
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    sp = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (st != 4'b0) sp++;
    end
    checks++;
    if (sp != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d start pulses, required 0", sp);
    end
    set_lat(1);
    push_run(2, 2, 0);
    run_start(2, 2);
    wait_done(200, "post_reset");

    repeat (5) @(negedge clk);
    checks++;
    if (exp_ev.size() != 0) begin
      errors++;
      $display("FAIL ev_drain: got %0d pending starts, required 0", exp_ev.size());
    end
    checks++;
    if (exp_res.size() != 0) begin
      errors++;
      $display("FAIL res_drain: got %0d pending results, required 0", exp_res.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
